// File: rtl/muldiv_unit.sv
// Iterative 8-bit unsigned multiply (shift-add) / divide (restoring) unit.
// Results go back to the register file as two writes: high/remainder to a register, then low/quotient to the accumulator.
module muldiv_unit #(
   parameter int pw   = 4,
   parameter int ITER = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          op,
   input  logic [7:0]    a_in,
   input  logic [7:0]    b_in,
   input  logic [pw:0]   dst_addr,
   output logic          busy,
   output logic          stall,
   output logic          done,
   output logic          dz,
   output logic [7:0]    wb_data,
   output logic [pw:0]   wb_addr,
   output logic          acc_write,
   output logic          reg_write,
   output logic [1:0]    dbg_state
);

   // Handshake: start is a one-cycle request honoured only while idle (busy low);
   // stall = start | busy holds the requester from the cycle start is raised until busy drops.
   typedef enum logic [1:0] {IDLE, CALC, WB_HI, WB_LO} state_t;

   localparam int CW = $clog2(ITER + 1);

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            op_q;
   logic [7:0]      a_q, b_q;
   logic [pw:0]     dst_q;
   logic [15:0]     prod;
   logic [7:0]      rem;
   logic [7:0]      quo;

   logic [8:0]      mul_sum;
   logic [15:0]     prod_step;
   logic [8:0]      rem_sh;
   logic [8:0]      rem_diff;
   logic            div_zero;
   logic            calc_last;
   logic [7:0]      res_hi, res_lo;

   assign stall     = start | busy;
   assign dbg_state = state;

   assign mul_sum   = {1'b0, prod[15:8]} + {1'b0, b_q};
   assign prod_step = prod[0] ? {mul_sum, prod[7:1]} : {1'b0, prod[15:1]};
   // rem < divisor always holds, so a borrow out of the 9-bit subtract shows up in bit 8.
   assign rem_sh    = {rem, quo[7]};
   assign rem_diff  = rem_sh - {1'b0, b_q};
   assign div_zero  = op_q && (b_q == 8'h00);
   assign calc_last = (cnt == CW'(ITER));
   assign res_hi    = div_zero ? a_q   : (op_q ? rem : prod[15:8]);
   assign res_lo    = div_zero ? 8'hFF : (op_q ? quo : prod[7:0]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (calc_last) state_nxt = WB_HI;
         WB_HI:   state_nxt = WB_LO;
         WB_LO:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered on the edge that enters each state, so the strobes line up with WB_HI / WB_LO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         op_q      <= 1'b0;
         a_q       <= 8'h00;
         b_q       <= 8'h00;
         dst_q     <= '0;
         prod      <= 16'h0000;
         rem       <= 8'h00;
         quo       <= 8'h00;
         busy      <= 1'b0;
         done      <= 1'b0;
         dz        <= 1'b0;
         wb_data   <= 8'h00;
         wb_addr   <= '0;
         acc_write <= 1'b0;
         reg_write <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= op;
                  a_q   <= a_in;
                  b_q   <= b_in;
                  dst_q <= dst_addr;
                  prod  <= {8'h00, a_in};
                  rem   <= 8'h00;
                  quo   <= a_in;
                  cnt   <= '0;
                  dz    <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            CALC: begin
               if (!calc_last) begin
                  cnt  <= cnt + 1'b1;
                  prod <= prod_step;
                  rem  <= rem_diff[8] ? rem_sh[7:0] : rem_diff[7:0];
                  quo  <= {quo[6:0], ~rem_diff[8]};
               end else begin
                  dz        <= div_zero;
                  wb_data   <= res_hi;
                  wb_addr   <= dst_q;
                  // Address 0 is the accumulator itself; the following low write supersedes it.
                  reg_write <= (dst_q != '0);
               end
            end
            WB_HI: begin
               reg_write <= 1'b0;
               acc_write <= 1'b1;
               done      <= 1'b1;
               wb_data   <= res_lo;
            end
            WB_LO: begin
               acc_write <= 1'b0;
               done      <= 1'b0;
               busy      <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative 8-bit multiply/divide unit sitting directly upstream of the accumulator register file.
- Consumes the register file's acc_out and reg_out as operands.
- Produces 8-bit write-back data with the matching AccWrite/RegWrite strobes over two sequential cycles, because the register file accepts only one write per clock and the accumulator write takes priority.
- Stalls the fetch/control path while busy.

Parameters:
pw, 4, register address pointer width; addresses are pw+1 bits wide, matching the register file.
ITER, 8, number of shift/add or shift/subtract iterations; equals the operand width.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request; sampled only in IDLE.
op  input  1  0 = unsigned multiply, 1 = unsigned divide.
a_in  input  8  operand A / dividend (from acc_out).
b_in  input  8  operand B / divisor (from reg_out).
dst_addr  input  pw+1  destination register for the high part / remainder.
busy  output  1  operation in progress.
stall  output  1  combinational: start OR busy; holds the PC/decoder.
done  output  1  one-cycle pulse in the final write-back cycle.
dz  output  1  divide-by-zero flag, sticky until the next accepted start.
wb_data  output  8  write-back data to the register file's dat_in.
wb_addr  output  pw+1  register address for the reg write.
acc_write  output  1  AccWrite strobe.
reg_write  output  1  RegWrite strobe.

Behaviour:
- Reset: async. State goes to IDLE; all registered outputs go to 0 (busy, done, dz, wb_data, wb_addr, acc_write, reg_write) and internal datapath registers clear. If reset lands mid-operation, the operation is abandoned and no strobe is asserted afterwards.
- FSM states: IDLE -> CALC -> WB_HI -> WB_LO -> IDLE.
- IDLE, start=1 at edge T:
  - latch a_in, b_in, op, dst_addr;
  - clear dz; set busy;
  - go to CALC with iteration counter = 0.
  - start in any other state is ignored; operands are not re-latched.
- CALC: one iteration per cycle for ITER cycles (edges T+1..T+8), then go to WB_HI.
  - Multiply: shift-add over a 16-bit product register.
  - Divide: restoring division. Remainder register is 9 bits, the subtract is 9-bit, quotient bits shift in LSB-first from dividend MSB.
- Divide with b=0: skip the arithmetic result. Quotient = 8'hFF, remainder = latched a. Set dz at the end of CALC. Cycle count is unchanged.
- WB_HI (one cycle):
  - wb_data = product[15:8] (mul) or remainder (div);
  - wb_addr = latched dst_addr; reg_write=1, acc_write=0.
  - If latched dst_addr == 0, reg_write is held 0 in this cycle, since the accumulator would be overwritten anyway.
- WB_LO (one cycle):
  - wb_data = product[7:0] (mul) or quotient (div);
  - acc_write=1, reg_write=0; done=1.
  - Go to IDLE; busy drops at the end of this cycle.
- acc_write and reg_write are never high in the same cycle.
- Total latency: start accepted at edge T; reg write at edge T+10, acc write at edge T+11. busy is high in the cycles between edges T and T+11.
- Back-to-back: a start presented the cycle after done is accepted (IDLE).
- stall is combinational, so the requesting instruction is held from the cycle start is raised.
- Widths: all arithmetic is unsigned with no overflow possible. Product fits in 16 bits; quotient ≤ 8'hFF.

Test Plan:
- Multiply 13 × 11, dst_addr=3 -> reg[3] written 8'h00 at T+10, acc written 8'h8F at T+11, done pulse at T+11 for one cycle, dz=0.
- Multiply 200 × 250 -> wb_data 8'hC3 with reg_write, then 8'h50 with acc_write; busy high exactly 11 cycles.
- Divide 200 / 7, dst_addr=5 -> reg[5]=8'h04 (remainder), acc=8'h1C (quotient), dz=0.
- Divide 8'h55 / 0 -> reg=8'h55, acc=8'hFF, dz=1 and held until the next start, which clears it.
- Multiply with dst_addr=0 -> no reg_write in WB_HI, acc_write 8'h(lo) only; start pulsed during CALC is ignored and the result is unchanged.
- Reset asserted at T+4 mid-CALC -> immediately busy=0, stall follows start only, no acc_write/reg_write ever; a fresh start after reset yields the correct result.
